// File: rtl/string_finder_pkg.sv
// Shared definitions for the serial stimulus / sequence-detector blocks:
// 2-bit state encoding and the power-on default pattern.
package string_finder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t GAP   = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

// File: rtl/pattern_serializer_bit_rotator.sv
// WIDTH-bit loadable left-rotate register; load has priority over enable.
// Resets asynchronously to PATTERN and exposes only its MSB.
module bit_rotator
    import string_finder_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEFAULT_PATTERN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb
);

    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;

    always_comb begin
        // NOTE: assign a default before any branch so no latch is inferred.
        reg_d = reg_q;
        if (load) begin
            reg_d = load_data;
        end else if (enable) begin
            reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            reg_q <= PATTERN;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign msb = reg_q[WIDTH-1];

endmodule

// File: rtl/pattern_serializer.sv
// Serializes a word MSB-first on x, (in_reps+1) times, then pulses done.
// Define SERIALIZER_GAP_EN to insert one idle GAP cycle between repetitions.
module pattern_serializer
    import string_finder_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEFAULT_PATTERN)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_reps,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int             IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             rot_load, rot_en, rot_msb;

    bit_rotator #(
        .WIDTH   (WIDTH),
        .PATTERN (PATTERN)
    ) u_rot (
        .clk       (clk),
        .rst_n     (clr),
        .load      (rot_load),
        .enable    (rot_en),
        .load_data (in_data),
        .msb       (rot_msb)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rep_d    = rep_q;
        rot_load = 1'b0;
        rot_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = SHIFT;
                    idx_d    = '0;
                    rep_d    = in_reps;
                    rot_load = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    rot_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // A full rotation restores the word, so a repeat needs no reload.
                        if (rep_q != '0) begin
                            rep_d = rep_q - CNT_W'(1);
                            idx_d = '0;
`ifdef SERIALIZER_GAP_EN
                            state_d = GAP;
`else
                            state_d = SHIFT;
`endif
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef SERIALIZER_GAP_EN
            GAP: begin
                state_d = abort ? IDLE : SHIFT;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
        x_valid  = (state_q == SHIFT);
        x        = (state_q == SHIFT) && rot_msb;
        busy     = (state_q == SHIFT) || (state_q == GAP);
        done     = (state_q == DONE);
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: queue-based reference model
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_pattern_serializer;

    logic       clk;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [7:0] in_reps;
    logic       abort;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;

    pattern_serializer #(
        .WIDTH   (4),
        .CNT_W   (8),
        .PATTERN (4'b1101)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_reps  (in_reps),
        .abort    (abort),
        .x        (x),
        .x_valid  (x_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic x;
        logic xv;
        logic busy;
        logic done;
        logic ready;
    } obs_t;

    obs_t exp_q[$];
    obs_t cur;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    logic s_x, s_xv, s_busy, s_done, s_ready;

    function automatic obs_t mk(input logic bx, input logic bxv, input logic bbusy,
                                input logic bdone, input logic bready);
        obs_t o;
        o.x     = bx;
        o.xv    = bxv;
        o.busy  = bbusy;
        o.done  = bdone;
        o.ready = bready;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: on each accept, lay out the whole expected cycle
    // sequence of the transfer; abort or reset discards what is left.
    task automatic model_edge();
        if (cur.busy && abort) begin
            exp_q.delete();
            cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end else if (cur.ready && in_valid) begin
            for (int r = 0; r <= int'(in_reps); r++) begin
                for (int b = 3; b >= 0; b--) begin
                    exp_q.push_back(mk(in_data[b], 1'b1, 1'b1, 1'b0, 1'b0));
                end
`ifdef SERIALIZER_GAP_EN
                if (r < int'(in_reps)) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
`endif
            end
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            cur = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        s_x     = x;
        s_xv    = x_valid;
        s_busy  = busy;
        s_done  = done;
        s_ready = in_ready;
        check($sformatf("cycle%0d outputs{x,xv,busy,done,ready}", cyc),
              {27'd0, x, x_valid, busy, done, in_ready}, {27'd0, cur});
    endtask

    task automatic send(input logic [3:0] d, input logic [7:0] r, input int max_cyc,
                        output int nvalid, output logic [31:0] bits, output int ndone,
                        output int done_cyc, output int ready_cyc, output logic [31:0] gapmask);
        nvalid    = 0;
        bits      = '0;
        ndone     = 0;
        done_cyc  = 0;
        ready_cyc = 0;
        gapmask   = '0;
        in_data   = d;
        in_reps   = r;
        in_valid  = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            in_valid = 1'b0;
            if (s_xv) begin
                bits = {bits[30:0], s_x};
                nvalid++;
            end else if (!s_done && !s_ready && c < 32) begin
                gapmask[c] = 1'b1;
            end
            if (s_done) begin
                ndone++;
                done_cyc = c;
            end
            if (ndone > 0 && s_ready) begin
                ready_cyc = c;
                break;
            end
        end
    endtask

    int          nv, nd, dc, rc;
    logic [31:0] bv, gm;

    initial begin
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_reps  = '0;
        abort    = 1'b0;
        cur      = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        #3;
        check("reset_outputs_low", {28'd0, x, x_valid, busy, done}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("reset_ready", {31'd0, in_ready}, 32'd1);
        check("reset_pattern", {28'd0, dut.u_rot.reg_q}, 32'hD);

        // Single word, no repeats.
        send(4'b1101, 8'd0, 20, nv, bv, nd, dc, rc, gm);
        check("w1_nbits", nv, 4);
        check("w1_bits", bv, 32'hD);
        check("w1_ndone", nd, 1);
        check("w1_done_cycle", dc, 5);
        check("w1_ready_cycle", rc, 6);

        // Three repetitions.
        send(4'b1011, 8'd2, 40, nv, bv, nd, dc, rc, gm);
        check("w2_nbits", nv, 12);
        check("w2_bits", bv, 32'hBBB);
        check("w2_ndone", nd, 1);
`ifdef SERIALIZER_GAP_EN
        check("w2_done_cycle", dc, 15);
        check("w2_gap_cycles", gm, 32'h420);
`else
        check("w2_done_cycle", dc, 13);
        check("w2_gap_cycles", gm, 32'h0);
`endif

        // Request held during a transfer is only taken after done.
        in_data  = 4'b1001;
        in_reps  = 8'd0;
        in_valid = 1'b1;
        tick();
        in_data = 4'b0110;
        nv = 1;
        bv = {31'd0, s_x};
        for (int c = 0; c < 20 && nv < 8; c++) begin
            tick();
            if (s_xv) begin
                bv = {bv[30:0], s_x};
                nv++;
            end
            if (s_xv && nv == 5) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("held_nbits", nv, 8);
        check("held_bits", bv, 32'h96);
        for (int c = 0; c < 10 && !s_ready; c++) tick();

        // Abort in the second bit cycle.
        in_data  = 4'b0110;
        in_reps  = 8'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_xvalid", {31'd0, s_xv}, 32'd0);
        check("abort_ready", {31'd0, s_ready}, 32'd1);
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (s_done) nd++;
        end
        check("abort_no_done", nd, 0);
        send(4'b1110, 8'd1, 30, nv, bv, nd, dc, rc, gm);
        check("post_abort_nbits", nv, 8);
        check("post_abort_bits", bv, 32'hEE);
        check("post_abort_ndone", nd, 1);

        // Asynchronous reset mid-word.
        in_data  = 4'b1011;
        in_reps  = 8'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("pre_clr_active", {31'd0, s_xv}, 32'd1);
        #2;
        clr = 1'b0;
        #1;
        check("clr_async_low", {28'd0, x, x_valid, busy, done}, 32'd0);
        exp_q.delete();
        cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr_ready", {31'd0, in_ready}, 32'd1);
        check("clr_pattern", {28'd0, dut.u_rot.reg_q}, 32'hD);
        tick();

        // Maximum repetition count: counter must not wrap.
        send(4'b1101, 8'd255, 1400, nv, bv, nd, dc, rc, gm);
        check("max_nbits", nv, 1024);
        check("max_bits", bv, 32'hDDDD_DDDD);
        check("max_ndone", nd, 1);
`ifdef SERIALIZER_GAP_EN
        check("max_done_cycle", dc, 1280);
`else
        check("max_done_cycle", dc, 1025);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 4'($urandom);
            in_reps  = 8'($urandom_range(0, 3));
            abort    = ($urandom_range(0, 15) == 0);
            tick();
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

- Serial stimulus transmitter for the bit-sequence detectors: accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on a single-bit line `x`, one bit per clock.
- Repeats the word a programmable number of times and pulses `done` when finished.
- Sits upstream of the serial sequence-detector FSMs; its `x` output drives a detector's `x` input directly.

## Interface
Parameters:
- `WIDTH`, 4, bits per word.
- `CNT_W`, 8, width of the repetition count.
- `PATTERN`, 4'b1101, power-on default word; loaded into the shift register at reset.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `clr`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request to send `in_data`.
- `in_ready`  out  1  block can accept a request.
- `in_data`  in  WIDTH  word to transmit, MSB first.
- `in_reps`  in  CNT_W  extra repetitions: value r sends the word r+1 times.
- `abort`  in  1  synchronous cancel of the current transfer.
- `x`  out  1  serial data bit.
- `x_valid`  out  1  `x` carries a payload bit this cycle.
- `busy`  out  1  transfer in progress (SHIFT or GAP).
- `done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: emitting bits.
  - GAP: only when the configuration macro is defined.
  - DONE: one cycle.
- Accept: `in_valid`&&`in_ready` at a clock edge.
  - Captures `in_data` into the shift register, `in_reps` into the rep counter, and clears the bit index.
  - Moves to SHIFT.
- SHIFT: `x` = shift-register MSB, `x_valid`=1. Each cycle the register rotates left by one and the bit index increments.
  - Index reaches WIDTH-1 with rep counter > 0: decrement the counter, reset the index, and continue with the same word (rotation restores it). Next state is SHIFT, or GAP with the macro.
  - Index reaches WIDTH-1 with rep counter = 0: go to DONE.
- DONE: `done`=1, `x_valid`=0, `in_ready`=0. Next state is IDLE.
- `abort` in SHIFT/GAP: the next state is IDLE directly; no `done`; `x_valid`=0 from the next cycle. `abort` in IDLE/DONE is ignored.
- `in_valid` while not ready: ignored, nothing is queued. The source must hold the request until it sees `in_ready`.
- `x` = 0 whenever `x_valid`=0.
- Counters: the bit index is $clog2(WIDTH) bits wide. The rep counter is CNT_W bits and never wraps; it only decrements while nonzero.
- Reset (`clr`=0, at any time including mid-word):
  - State IDLE, shift register = PATTERN, counters 0.
  - `x`=0, `x_valid`=0, `busy`=0, `done`=0, `in_ready`=1 as soon as the reset is released.
  - A partial word is lost.

## Timing
- All outputs are registered, or decoded from registered state only. There is no combinational input-to-output path.
- Latency: accept at edge k → first bit valid in cycle k+1.
- Word bits occupy cycles k+1 … k+WIDTH·(r+1) without the macro.
- `done` follows in the cycle after the last bit. `in_ready` returns one cycle after that.
- Minimum spacing between accepts: WIDTH·(r+1)+2 cycles.
- `abort` sampled at edge j: `x_valid`=0 in cycle j+1; `in_ready`=1 in cycle j+1.
- `abort` coincident with the last bit: abort wins, no `done`.

## Configuration
- `SERIALIZER_GAP_EN` defined:
  - One GAP cycle is inserted between repetitions, with `x_valid`=0, `x`=0 and `busy`=1.
  - Total transfer is WIDTH·(r+1)+r cycles.
  - No GAP cycle after the last repetition.
- Undefined: repetitions are back-to-back and the GAP state does not exist.

## Structure
- Shared package `string_finder_pkg`:
  - State encoding constants: IDLE, SHIFT, GAP, DONE as 2-bit localparams.
  - Default pattern constant 4'b1101, used as the PATTERN default.
- Sub-module `bit_rotator`:
  - WIDTH-bit loadable left-rotate register, asynchronous active-low reset to PATTERN.
  - Controls: load, enable.
  - Outputs: MSB.
- The FSM, rep counter and bit index live in the top module.

## Test plan
- Reset, then accept `in_data`=4'b1101, `in_reps`=0 → `x` = 1,1,0,1 in cycles 1–4 with `x_valid`=1; `done` in cycle 5; `in_ready`=1 in cycle 6. When `x` drives a detector, the detector's `out` asserts while the 4th bit is applied.
- `in_data`=4'b1011, `in_reps`=2 → 12 contiguous valid bits 1011 1011 1011, exactly one `done`. With `SERIALIZER_GAP_EN`: 14 cycles, with `x_valid`=0 in cycles 5 and 10.
- `in_valid` held high during SHIFT with different data → second word accepted only after `done`; first word is unchanged on `x`.
- `abort` asserted in the 2nd bit cycle of `in_reps`=3 → `x_valid`=0 the next cycle, no `done`, `in_ready`=1, and a new accept works normally.
- `clr` pulsed low mid-word → `x`, `x_valid`, `busy` and `done` drop to 0 asynchronously; after release `in_ready`=1 and the shift register holds 4'b1101.
- `in_reps`=255 (CNT_W=8) → 1024 bits then `done`; the counter does not wrap.
